// File: rtl/alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_pipe
// Description : Handshaked ALU-control stage for the pipelined LEGv8
//               datapath. Decodes {ALUOp, opcode} into an ALU operation
//               code, registers it, flags multi-cycle ops (MUL/UDIV) and
//               stalls new decodes while the execute unit works on them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_pipe #(
    parameter int OPC_W   = 11,
    parameter int OP_W    = 4,
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       aluop,
    input  logic [OPC_W-1:0] opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OP_W-1:0]  out_op,
    output logic             out_multi,
    output logic             out_illegal,
    output logic             busy,
    output logic [CNT_W-1:0] illegal_cnt
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [0:0] c_ST_RUN  = 1'b0;
    localparam logic [0:0] c_ST_WAIT = 1'b1;

    // R-type opcodes: full instruction[31:21] field
    localparam logic [OPC_W-1:0] c_OPC_ADD  = OPC_W'(11'b10001011000);
    localparam logic [OPC_W-1:0] c_OPC_SUB  = OPC_W'(11'b11001011000);
    localparam logic [OPC_W-1:0] c_OPC_AND  = OPC_W'(11'b10001010000);
    localparam logic [OPC_W-1:0] c_OPC_ORR  = OPC_W'(11'b10101010000);
    localparam logic [OPC_W-1:0] c_OPC_EOR  = OPC_W'(11'b11001010000);
    localparam logic [OPC_W-1:0] c_OPC_LSL  = OPC_W'(11'b11010011011);
    localparam logic [OPC_W-1:0] c_OPC_LSR  = OPC_W'(11'b11010011010);
    localparam logic [OPC_W-1:0] c_OPC_MUL  = OPC_W'(11'b10011011000);
    localparam logic [OPC_W-1:0] c_OPC_UDIV = OPC_W'(11'b10011010110);

    // I-type opcodes: only the upper ten bits identify the instruction
    localparam logic [OPC_W-2:0] c_IOPC_ADDI = (OPC_W-1)'(10'b1001000100);
    localparam logic [OPC_W-2:0] c_IOPC_SUBI = (OPC_W-1)'(10'b1101000100);
    localparam logic [OPC_W-2:0] c_IOPC_ANDI = (OPC_W-1)'(10'b1001001000);
    localparam logic [OPC_W-2:0] c_IOPC_ORRI = (OPC_W-1)'(10'b1011001000);

    // ALU operation codes
    localparam logic [OP_W-1:0] c_OP_AND   = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] c_OP_ORR   = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] c_OP_ADD   = OP_W'(4'b0010);
    localparam logic [OP_W-1:0] c_OP_EOR   = OP_W'(4'b0011);
    localparam logic [OP_W-1:0] c_OP_SUB   = OP_W'(4'b0110);
    localparam logic [OP_W-1:0] c_OP_PASSB = OP_W'(4'b0111);
    localparam logic [OP_W-1:0] c_OP_LSL   = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] c_OP_LSR   = OP_W'(4'b1001);
    localparam logic [OP_W-1:0] c_OP_MUL   = OP_W'(4'b1010);
    localparam logic [OP_W-1:0] c_OP_UDIV  = OP_W'(4'b1011);
    localparam logic [OP_W-1:0] c_OP_ILL   = OP_W'(4'b1111);

    // Wait counter only has to hold the larger latency minus one
    localparam int c_LAT_MAX = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int c_WCNT_W  = (c_LAT_MAX > 1) ? $clog2(c_LAT_MAX) : 1;

    localparam logic [c_WCNT_W-1:0] c_MUL_LOAD = c_WCNT_W'(MUL_LAT - 1);
    localparam logic [c_WCNT_W-1:0] c_DIV_LOAD = c_WCNT_W'(DIV_LAT - 1);
    localparam logic [c_WCNT_W-1:0] c_WCNT_ONE = c_WCNT_W'(1);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]          r_state;
    logic [c_WCNT_W-1:0] r_wait_cnt;
    logic                r_out_valid;
    logic [OP_W-1:0]     r_out_op;
    logic                r_out_multi;
    logic                r_out_illegal;
    logic [CNT_W-1:0]    r_illegal_cnt;

    logic [OP_W-1:0]     w_dec_op;
    logic                w_dec_multi;
    logic                w_dec_illegal;
    logic                w_in_ready;
    logic                w_accept;
    logic                w_fire;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // A multi-cycle op leaving the stage sends us to WAIT, so no new decode
    // may be taken on the cycle it fires.
    assign w_in_ready = (r_state == c_ST_RUN) &&
                        (!r_out_valid || (out_ready && !r_out_multi));
    assign w_accept   = in_valid && w_in_ready;
    assign w_fire     = r_out_valid && out_ready;

    // Decode {aluop, opcode}; anything unmatched falls through to illegal
    always_comb begin
        w_dec_op      = c_OP_ILL;
        w_dec_multi   = 1'b0;
        w_dec_illegal = 1'b1;
        case (aluop)
            2'b00: begin
                w_dec_op      = c_OP_ADD;
                w_dec_illegal = 1'b0;
            end
            2'b01: begin
                w_dec_op      = c_OP_PASSB;
                w_dec_illegal = 1'b0;
            end
            2'b10: begin
                case (opcode)
                    c_OPC_ADD: begin
                        w_dec_op      = c_OP_ADD;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_SUB: begin
                        w_dec_op      = c_OP_SUB;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_AND: begin
                        w_dec_op      = c_OP_AND;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_ORR: begin
                        w_dec_op      = c_OP_ORR;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_EOR: begin
                        w_dec_op      = c_OP_EOR;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_LSL: begin
                        w_dec_op      = c_OP_LSL;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_LSR: begin
                        w_dec_op      = c_OP_LSR;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_MUL: begin
                        w_dec_op      = c_OP_MUL;
                        w_dec_multi   = 1'b1;
                        w_dec_illegal = 1'b0;
                    end
                    c_OPC_UDIV: begin
                        w_dec_op      = c_OP_UDIV;
                        w_dec_multi   = 1'b1;
                        w_dec_illegal = 1'b0;
                    end
                    default: begin
                        w_dec_op      = c_OP_ILL;
                    end
                endcase
            end
            2'b11: begin
                case (opcode[OPC_W-1:1])
                    c_IOPC_ADDI: begin
                        w_dec_op      = c_OP_ADD;
                        w_dec_illegal = 1'b0;
                    end
                    c_IOPC_SUBI: begin
                        w_dec_op      = c_OP_SUB;
                        w_dec_illegal = 1'b0;
                    end
                    c_IOPC_ANDI: begin
                        w_dec_op      = c_OP_AND;
                        w_dec_illegal = 1'b0;
                    end
                    c_IOPC_ORRI: begin
                        w_dec_op      = c_OP_ORR;
                        w_dec_illegal = 1'b0;
                    end
                    default: begin
                        w_dec_op      = c_OP_ILL;
                    end
                endcase
            end
            default: begin
                w_dec_op      = c_OP_ILL;
            end
        endcase
    end

    // Output register and RUN/WAIT control
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_RUN;
            r_wait_cnt    <= '0;
            r_out_valid   <= 1'b0;
            r_out_op      <= '0;
            r_out_multi   <= 1'b0;
            r_out_illegal <= 1'b0;
        end else if (r_state == c_ST_RUN) begin
            if (w_accept) begin
                // A new decode replaces the output; a single-cycle op may
                // be firing on this same edge.
                r_out_valid   <= 1'b1;
                r_out_op      <= w_dec_op;
                r_out_multi   <= w_dec_multi;
                r_out_illegal <= w_dec_illegal;
            end else if (w_fire) begin
                r_out_valid <= 1'b0;
                if (r_out_multi) begin
                    r_state    <= c_ST_WAIT;
                    r_wait_cnt <= (r_out_op == c_OP_MUL) ? c_MUL_LOAD : c_DIV_LOAD;
                end
            end
        end else begin
            // WAIT: loaded with LAT-1, so the state lasts exactly LAT cycles
            if (r_wait_cnt == '0) begin
                r_state <= c_ST_RUN;
            end else begin
                r_wait_cnt <= r_wait_cnt - c_WCNT_ONE;
            end
        end
    end

    // Saturating count of accepted illegal decodes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_accept && w_dec_illegal && (r_illegal_cnt != c_CNT_MAX)) begin
            r_illegal_cnt <= r_illegal_cnt + c_CNT_ONE;
        end
    end

    assign in_ready    = w_in_ready;
    assign out_valid   = r_out_valid;
    assign out_op      = r_out_op;
    assign out_multi   = r_out_multi;
    assign out_illegal = r_out_illegal;
    assign busy        = (r_state == c_ST_WAIT);
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_pipe
// Description : Self-checking bench for alu_control_pipe. Decode table
//               vectors feed a scoreboard queue; hand-written sequences
//               cover throughput, multi-cycle waits, stalls, counter
//               saturation and reset during WAIT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [10:0] opcode;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_op;
    logic        out_multi;
    logic        out_illegal;
    logic        busy;
    logic [7:0]  illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    logic [5:0] exp_q[$];

    typedef struct {
        logic [1:0]  a;
        logic [10:0] o;
        logic [3:0]  op;
        logic        m;
        logic        il;
    } vec_t;

    vec_t tbl[20];

    alu_control_pipe #(
        .OPC_W  (11),
        .OP_W   (4),
        .MUL_LAT(3),
        .DIV_LAT(8),
        .CNT_W  (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .aluop      (aluop),
        .opcode     (opcode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op     (out_op),
        .out_multi  (out_multi),
        .out_illegal(out_illegal),
        .busy       (busy),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: compare every output fire against the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_unexpected: got op=0x%0h with empty queue (t=%0t)", out_op, $time);
            end else begin
                check("sb_out", {26'd0, out_op, out_multi, out_illegal}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    // Present one decode, wait (bounded) for acceptance, return after the edge
    task automatic send(input logic [1:0] a, input logic [10:0] o, input logic [3:0] eop,
                        input logic em, input logic ei, output int waits);
        logic acc;
        aluop    = a;
        opcode   = o;
        in_valid = 1'b1;
        waits    = 0;
        acc      = 1'b0;
        while (!acc && waits < 50) begin
            @(negedge clk);
            if (in_ready) acc = 1'b1;
            else waits++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose, got 0 expected 1 (t=%0t)", $time);
        end else begin
            exp_q.push_back({eop, em, ei});
            if (ei && exp_cnt < 255) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // After a multi-cycle op is in the output register: count WAIT cycles
    task automatic measure_wait(input string name, input int exp_len);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        while (busy && n < 40) begin
            if (in_ready) ok = 1'b0;
            n++;
            @(posedge clk);
            #1;
        end
        check({name, "_len"}, n, exp_len);
        check({name, "_ready_low"}, {31'd0, ok}, 32'd1);
        check({name, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int w;

        tbl[0]  = '{2'b10, 11'b10001011000, 4'b0010, 1'b0, 1'b0};
        tbl[1]  = '{2'b10, 11'b11001011000, 4'b0110, 1'b0, 1'b0};
        tbl[2]  = '{2'b10, 11'b10001010000, 4'b0000, 1'b0, 1'b0};
        tbl[3]  = '{2'b10, 11'b10101010000, 4'b0001, 1'b0, 1'b0};
        tbl[4]  = '{2'b10, 11'b11001010000, 4'b0011, 1'b0, 1'b0};
        tbl[5]  = '{2'b10, 11'b11010011011, 4'b1000, 1'b0, 1'b0};
        tbl[6]  = '{2'b10, 11'b11010011010, 4'b1001, 1'b0, 1'b0};
        tbl[7]  = '{2'b10, 11'b10011011000, 4'b1010, 1'b1, 1'b0};
        tbl[8]  = '{2'b10, 11'b10011010110, 4'b1011, 1'b1, 1'b0};
        tbl[9]  = '{2'b11, 11'b10010001000, 4'b0010, 1'b0, 1'b0};
        tbl[10] = '{2'b11, 11'b11010001001, 4'b0110, 1'b0, 1'b0};
        tbl[11] = '{2'b11, 11'b10010010000, 4'b0000, 1'b0, 1'b0};
        tbl[12] = '{2'b11, 11'b10110010001, 4'b0001, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 11'b11111111111, 4'b0010, 1'b0, 1'b0};
        tbl[14] = '{2'b01, 11'b00000000000, 4'b0111, 1'b0, 1'b0};
        tbl[15] = '{2'b10, 11'b11111111111, 4'b1111, 1'b0, 1'b1};
        tbl[16] = '{2'b11, 11'b11111111111, 4'b1111, 1'b0, 1'b1};
        tbl[17] = '{2'b10, 11'b10010001000, 4'b1111, 1'b0, 1'b1};
        tbl[18] = '{2'b11, 11'b10001011000, 4'b1111, 1'b0, 1'b1};
        tbl[19] = '{2'b10, 11'b10001011001, 4'b1111, 1'b0, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        aluop     = 2'b00;
        opcode    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_op", {28'd0, out_op}, 32'd0);
        check("rst_out_multi", {31'd0, out_multi}, 32'd0);
        check("rst_out_illegal", {31'd0, out_illegal}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single SUB: visible one cycle after acceptance
        send(2'b10, 11'b11001011000, 4'b0110, 1'b0, 1'b0, w);
        check("sub_valid", {31'd0, out_valid}, 32'd1);
        check("sub_op", {28'd0, out_op}, 32'h6);
        check("sub_multi", {31'd0, out_multi}, 32'd0);
        idle(2);

        // Back-to-back ADD, ORR, AND at full throughput
        send(2'b10, 11'b10001011000, 4'b0010, 1'b0, 1'b0, w);
        check("b2b_add_wait", w, 0);
        check("b2b_add_op", {28'd0, out_op}, 32'h2);
        send(2'b10, 11'b10101010000, 4'b0001, 1'b0, 1'b0, w);
        check("b2b_orr_wait", w, 0);
        check("b2b_orr_op", {28'd0, out_op}, 32'h1);
        send(2'b10, 11'b10001010000, 4'b0000, 1'b0, 1'b0, w);
        check("b2b_and_wait", w, 0);
        check("b2b_and_op", {28'd0, out_op}, 32'h0);
        idle(2);

        // MUL: three WAIT cycles
        send(2'b10, 11'b10011011000, 4'b1010, 1'b1, 1'b0, w);
        check("mul_multi", {31'd0, out_multi}, 32'd1);
        measure_wait("mul_wait", 3);

        // UDIV: eight WAIT cycles
        send(2'b10, 11'b10011010110, 4'b1011, 1'b1, 1'b0, w);
        check("udiv_multi", {31'd0, out_multi}, 32'd1);
        measure_wait("udiv_wait", 8);
        idle(1);

        // Stall: SUB held for 4 cycles, then ORR accepted on release
        out_ready = 1'b0;
        send(2'b10, 11'b11001011000, 4'b0110, 1'b0, 1'b0, w);
        aluop    = 2'b10;
        opcode   = 11'b10101010000;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("stall_op", {28'd0, out_op}, 32'h6);
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);
        send(2'b10, 11'b10101010000, 4'b0001, 1'b0, 1'b0, w);
        check("release_wait", w, 0);
        check("release_op", {28'd0, out_op}, 32'h1);
        idle(2);

        // Full decode table
        for (int i = 0; i < 20; i++) begin
            send(tbl[i].a, tbl[i].o, tbl[i].op, tbl[i].m, tbl[i].il, w);
        end
        idle(12);
        check("table_illegal_cnt", {24'd0, illegal_cnt}, exp_cnt);

        // Illegal counter saturation
        for (int i = 0; i < 300; i++) begin
            send(2'b10, 11'b11111111111, 4'b1111, 1'b0, 1'b1, w);
            if (i == 0) begin
                check("ill_op", {28'd0, out_op}, 32'hF);
                check("ill_flag", {31'd0, out_illegal}, 32'd1);
            end
        end
        idle(2);
        check("ill_sat", {24'd0, illegal_cnt}, 32'd255);
        check("ill_sat_model", {24'd0, illegal_cnt}, exp_cnt);

        // Reset during UDIV WAIT (cycle 4 of 8)
        send(2'b10, 11'b10011010110, 4'b1011, 1'b1, 1'b0, w);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rstw_busy_pre", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_cnt = 0;
        exp_q.delete();
        check("rstw_busy", {31'd0, busy}, 32'd0);
        check("rstw_out_valid", {31'd0, out_valid}, 32'd0);
        check("rstw_in_ready", {31'd0, in_ready}, 32'd1);
        check("rstw_illegal_cnt", {24'd0, illegal_cnt}, 32'd0);

        // Recovery after reset
        send(2'b00, 11'b00000000000, 4'b0010, 1'b0, 1'b0, w);
        check("recover_op", {28'd0, out_op}, 32'h2);
        idle(3);
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
